lcd_dither_out: RTL and testbench

- Output stage directly downstream of the VGA/LCD timing generator.
- Consumes its registered hs/vs/de/24-bit RGB stream and drives a 16-bit RGB565 LCD panel bus.
- Applies optional 4x4 ordered (Bayer) dithering before truncation and keeps sync and data aligned through a fixed 2-cycle pipeline.
- Checks active-line length and active-line count per frame, with error reporting.

---
 rtl/lcd_dither_out.sv | 206 ++++++++++++++++++++
 tb/tb_lcd_dither_out.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_dither_out.sv
// LCD panel output stage: RGB888 -> RGB565 with optional 4x4 ordered dithering,
// a fixed 2-cycle sync/data pipeline and active-area geometry checking.
module lcd_dither_out #(
  parameter int H_ACTIVE = 480,
  parameter int V_ACTIVE = 272,
  parameter int CNT_W    = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_hs,
  input  logic        in_vs,
  input  logic        in_de,
  input  logic [23:0] in_rgb,
  input  logic        dither_en,
  input  logic        err_clr,
  output logic        out_hs,
  output logic        out_vs,
  output logic        out_de,
  output logic [4:0]  out_r,
  output logic [5:0]  out_g,
  output logic [4:0]  out_b,
  output logic        frame_start,
  output logic        line_err,
  output logic        frame_err
);

  localparam logic [CNT_W-1:0] CNT_ZERO_C = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE_C  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX_C  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] H_ACT_C    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_C    = CNT_W'(V_ACTIVE);

  function automatic logic [3:0] bayer_m(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] m;
    case ({row, col})
      4'd0:    m = 4'd0;
      4'd1:    m = 4'd8;
      4'd2:    m = 4'd2;
      4'd3:    m = 4'd10;
      4'd4:    m = 4'd12;
      4'd5:    m = 4'd4;
      4'd6:    m = 4'd14;
      4'd7:    m = 4'd6;
      4'd8:    m = 4'd3;
      4'd9:    m = 4'd11;
      4'd10:   m = 4'd1;
      4'd11:   m = 4'd9;
      4'd12:   m = 4'd15;
      4'd13:   m = 4'd7;
      4'd14:   m = 4'd13;
      4'd15:   m = 4'd5;
      default: m = 4'd0;
    endcase
    return m;
  endfunction

  function automatic logic [7:0] sat_add8(input logic [7:0] v, input logic [3:0] t);
    logic [8:0] sum;
    logic [7:0] res;
    sum = {1'b0, v} + {5'b00000, t};
    if (sum[8]) begin
      res = 8'hFF;
    end else begin
      res = sum[7:0];
    end
    return res;
  endfunction

  logic             hs1_r, vs1_r, de1_r, dith1_r, fs1_r, err1_r;
  logic [23:0]      rgb1_r;
  logic [1:0]       xi1_r, yi1_r;
  logic [CNT_W-1:0] x_r, y_r;
  logic             armed_r;

  logic             de_fall_s, vs_fall_s, line_bad_s, frame_bad_s;
  logic [CNT_W-1:0] x_inc_s, y_inc_s, y_end_s;
  logic [3:0]       m_s, t_rb_s, t_g_s;
  logic [7:0]       r_sat_s, g_sat_s, b_sat_s;
  logic [4:0]       r_nxt_s, b_nxt_s;
  logic [5:0]       g_nxt_s;

  // Edge detection, saturating counter increments and geometry checks.
  // A line ending in the same cycle as vs falling is counted before the frame check.
  always_comb begin
    de_fall_s = de1_r & ~in_de;
    vs_fall_s = vs1_r & ~in_vs;
    if (x_r == CNT_MAX_C) begin
      x_inc_s = x_r;
    end else begin
      x_inc_s = x_r + CNT_ONE_C;
    end
    if (y_r == CNT_MAX_C) begin
      y_inc_s = y_r;
    end else begin
      y_inc_s = y_r + CNT_ONE_C;
    end
    if (de_fall_s) begin
      y_end_s = y_inc_s;
    end else begin
      y_end_s = y_r;
    end
    line_bad_s  = armed_r & de_fall_s & (x_r != H_ACT_C);
    frame_bad_s = armed_r & vs_fall_s & (y_end_s != V_ACT_C);
  end

  // Stage 1: input capture, pixel position tracking and error detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hs1_r   <= 1'b1;
      vs1_r   <= 1'b1;
      de1_r   <= 1'b0;
      rgb1_r  <= 24'h000000;
      dith1_r <= 1'b0;
      xi1_r   <= 2'b00;
      yi1_r   <= 2'b00;
      fs1_r   <= 1'b0;
      err1_r  <= 1'b0;
      x_r     <= CNT_ZERO_C;
      y_r     <= CNT_ZERO_C;
      armed_r <= 1'b0;
    end else begin
      hs1_r   <= in_hs;
      vs1_r   <= in_vs;
      de1_r   <= in_de;
      rgb1_r  <= in_rgb;
      dith1_r <= dither_en;
      xi1_r   <= x_r[1:0];
      yi1_r   <= y_r[1:0];
      fs1_r   <= in_de & (x_r == CNT_ZERO_C) & (y_r == CNT_ZERO_C);
      err1_r  <= line_bad_s | frame_bad_s;
      if (in_de) begin
        x_r <= x_inc_s;
      end else begin
        x_r <= CNT_ZERO_C;
      end
      if (vs_fall_s) begin
        y_r <= CNT_ZERO_C;
      end else if (de_fall_s) begin
        y_r <= y_inc_s;
      end else begin
        y_r <= y_r;
      end
      if (vs_fall_s) begin
        armed_r <= 1'b1;
      end else begin
        armed_r <= armed_r;
      end
    end
  end

  // Threshold lookup and saturating add; blanking forces the colour bus to zero.
  always_comb begin
    m_s = bayer_m(yi1_r, xi1_r);
    if (dith1_r) begin
      t_rb_s = m_s >> 1;
      t_g_s  = m_s >> 2;
    end else begin
      t_rb_s = 4'd0;
      t_g_s  = 4'd0;
    end
    r_sat_s = sat_add8(rgb1_r[23:16], t_rb_s);
    g_sat_s = sat_add8(rgb1_r[15:8],  t_g_s);
    b_sat_s = sat_add8(rgb1_r[7:0],   t_rb_s);
    if (de1_r) begin
      r_nxt_s = 5'(r_sat_s >> 3);
      g_nxt_s = 6'(g_sat_s >> 2);
      b_nxt_s = 5'(b_sat_s >> 3);
    end else begin
      r_nxt_s = 5'd0;
      g_nxt_s = 6'd0;
      b_nxt_s = 5'd0;
    end
  end

  // Stage 2: registered panel outputs and status flags; a new error beats err_clr.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_hs      <= 1'b1;
      out_vs      <= 1'b1;
      out_de      <= 1'b0;
      out_r       <= 5'd0;
      out_g       <= 6'd0;
      out_b       <= 5'd0;
      frame_start <= 1'b0;
      line_err    <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      out_hs      <= hs1_r;
      out_vs      <= vs1_r;
      out_de      <= de1_r;
      out_r       <= r_nxt_s;
      out_g       <= g_nxt_s;
      out_b       <= b_nxt_s;
      frame_start <= fs1_r;
      line_err    <= err1_r;
      if (err1_r) begin
        frame_err <= 1'b1;
      end else if (err_clr) begin
        frame_err <= 1'b0;
      end else begin
        frame_err <= frame_err;
      end
    end
  end

endmodule

// File: tb/tb_lcd_dither_out.sv
// Self-checking bench for lcd_dither_out: random pixel/dither stimulus against
// a behavioural reference model, plus directed pixel, reset and error scenarios.
module tb_lcd_dither_out;

  localparam int H_ACT = 40;
  localparam int V_ACT = 8;
  localparam int H_TOT = 52;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_hs = 1'b1, in_vs = 1'b1, in_de = 1'b0;
  logic [23:0] in_rgb = 24'h000000;
  logic        dither_en = 1'b0, err_clr = 1'b0;
  logic        out_hs, out_vs, out_de;
  logic [4:0]  out_r, out_b;
  logic [5:0]  out_g;
  logic        frame_start, line_err, frame_err;

  lcd_dither_out #(.H_ACTIVE(H_ACT), .V_ACTIVE(V_ACT), .CNT_W(12)) dut (
    .clk(clk), .rst(rst), .in_hs(in_hs), .in_vs(in_vs), .in_de(in_de),
    .in_rgb(in_rgb), .dither_en(dither_en), .err_clr(err_clr),
    .out_hs(out_hs), .out_vs(out_vs), .out_de(out_de),
    .out_r(out_r), .out_g(out_g), .out_b(out_b),
    .frame_start(frame_start), .line_err(line_err), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       hs, vs, de;
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
    logic       fs, err;
  } exp_t;

  exp_t q[$];
  int   n_err = 0, n_chk = 0;
  int   le_cnt = 0, fs_cnt = 0;
  int   dith_mode = 0;
  int   clr_lo = -1, clr_hi = -1;
  logic fe_exp = 1'b0;
  int   bayer [4][4] = '{'{0, 8, 2, 10}, '{12, 4, 14, 6}, '{3, 11, 1, 9}, '{15, 7, 13, 5}};

  // reference model state: previous inputs, pixel within line, lines since vs fall
  bit m_prev_de, m_prev_vs, m_armed;
  int m_px, m_ln;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic int sat_shift(input int v, input int t, input int sh);
    int s;
    s = v + t;
    if (s > 255) s = 255;
    return s >> sh;
  endfunction

  task automatic model_reset();
    exp_t e;
    m_prev_de = 1'b0; m_prev_vs = 1'b1; m_armed = 1'b0; m_px = 0; m_ln = 0;
    fe_exp = 1'b0;
    q.delete();
    e = '0; e.hs = 1'b1; e.vs = 1'b1;
    q.push_back(e);
  endtask

  task automatic model_push();
    exp_t e;
    bit   de_fall, vs_fall;
    int   m, t_rb, t_g;
    de_fall = m_prev_de && !in_de;
    vs_fall = m_prev_vs && !in_vs;
    e = '0;
    e.hs = in_hs; e.vs = in_vs; e.de = in_de;
    if (in_de) begin
      m    = dither_en ? bayer[m_ln % 4][m_px % 4] : 0;
      t_rb = m / 2;
      t_g  = m / 4;
      e.r  = 5'(sat_shift(int'(in_rgb[23:16]), t_rb, 3));
      e.g  = 6'(sat_shift(int'(in_rgb[15:8]),  t_g,  2));
      e.b  = 5'(sat_shift(int'(in_rgb[7:0]),   t_rb, 3));
    end
    e.fs  = in_de && (m_px == 0) && (m_ln == 0);
    e.err = m_armed && ((de_fall && m_px != H_ACT) ||
                        (vs_fall && (m_ln + int'(de_fall)) != V_ACT));
    if (in_de) m_px++; else m_px = 0;
    if (vs_fall) m_ln = 0; else if (de_fall) m_ln++;
    if (vs_fall) m_armed = 1'b1;
    m_prev_de = in_de; m_prev_vs = in_vs;
    q.push_back(e);
  endtask

  task automatic step();
    exp_t e;
    model_push();
    @(posedge clk);
    #1;
    e = q.pop_front();
    fe_exp = e.err ? 1'b1 : (err_clr ? 1'b0 : fe_exp);
    chk("hs",  32'(out_hs),      32'(e.hs));
    chk("vs",  32'(out_vs),      32'(e.vs));
    chk("de",  32'(out_de),      32'(e.de));
    chk("r",   32'(out_r),       32'(e.r));
    chk("g",   32'(out_g),       32'(e.g));
    chk("b",   32'(out_b),       32'(e.b));
    chk("fs",  32'(frame_start), 32'(e.fs));
    chk("le",  32'(line_err),    32'(e.err));
    chk("fe",  32'(frame_err),   32'(fe_exp));
    if (line_err) le_cnt++;
    if (frame_start) fs_cnt++;
  endtask

  task automatic check_reset();
    chk("rst_hs", 32'(out_hs), 32'd1);
    chk("rst_vs", 32'(out_vs), 32'd1);
    chk("rst_de", 32'(out_de), 32'd0);
    chk("rst_rgb", {16'd0, out_r, out_g, out_b}, 32'd0);
    chk("rst_fs", 32'(frame_start), 32'd0);
    chk("rst_le", 32'(line_err), 32'd0);
    chk("rst_fe", 32'(frame_err), 32'd0);
  endtask

  task automatic line_range(input int c0, input int c1, input int n_de, input logic vs_v);
    for (int c = c0; c < c1; c++) begin
      in_de     = (c < n_de);
      in_hs     = !(c >= H_ACT + 2 && c < H_ACT + 6);
      in_vs     = vs_v;
      in_rgb    = 24'($urandom);
      dither_en = (dith_mode == 2) ? 1'($urandom_range(0, 1)) : 1'(dith_mode);
      err_clr   = (c >= clr_lo && c <= clr_hi);
      step();
    end
    err_clr = 1'b0;
  endtask

  task automatic lines(input int from, input int to, input int short_ln);
    for (int l = from; l < to; l++)
      line_range(0, H_TOT, (l == short_ln) ? H_ACT - 1 : H_ACT, 1'b1);
  endtask

  task automatic vblank();
    line_range(0, H_TOT, 0, 1'b1);
    line_range(0, H_TOT, 0, 1'b0);
    line_range(0, H_TOT, 0, 1'b0);
    line_range(0, H_TOT, 0, 1'b1);
  endtask

  task automatic pix(input logic [23:0] rgb, input logic dith);
    in_de = 1'b1; in_hs = 1'b1; in_vs = 1'b1; err_clr = 1'b0;
    in_rgb = rgb; dither_en = dith;
    step();
  endtask

  initial begin
    // power-on reset
    repeat (2) @(posedge clk);
    #1;
    check_reset();
    rst = 1'b0;
    model_reset();

    // first frame is unchecked (arms at its vs falling edge)
    dith_mode = 2; le_cnt = 0; fs_cnt = 0;
    lines(0, V_ACT, -1); vblank();
    chk("f1_le_cnt", le_cnt, 0);
    chk("f1_fs_cnt", fs_cnt, 1);

    // armed good frame with random dithering
    le_cnt = 0; fs_cnt = 0;
    lines(0, V_ACT, -1); vblank();
    chk("f2_le_cnt", le_cnt, 0);
    chk("f2_fs_cnt", fs_cnt, 1);
    chk("f2_fe", 32'(frame_err), 32'd0);

    // async reset in the middle of an active line, then resume the partial line
    lines(0, 2, -1);
    line_range(0, 20, H_ACT, 1'b1);
    #2 rst = 1'b1;
    #1 check_reset();
    @(posedge clk);
    #1 check_reset();
    rst = 1'b0;
    model_reset();
    le_cnt = 0;
    line_range(20, H_TOT, H_ACT, 1'b1);
    lines(3, V_ACT, -1); vblank();
    chk("rst_partial_le_cnt", le_cnt, 0);

    // directed dithering / truncation / saturation pixels
    le_cnt = 0; fs_cnt = 0; dith_mode = 0;
    pix(24'hFFB6C1, 1'b1);
    pix(24'hFFB6C1, 1'b1);
    chk("dir_x0y0_g", 32'(out_g), 32'h2D);
    chk("dir_x0y0_fs", 32'(frame_start), 32'd1);
    pix(24'hFFB6C1, 1'b0);
    chk("dir_x1y0_r", 32'(out_r), 32'h1F);
    chk("dir_x1y0_g", 32'(out_g), 32'h2E);
    chk("dir_x1y0_b", 32'(out_b), 32'h18);
    pix(24'h123456, 1'b0);
    chk("plain_r", 32'(out_r), 32'h1F);
    chk("plain_g", 32'(out_g), 32'h2D);
    chk("plain_b", 32'(out_b), 32'h18);
    line_range(4, H_TOT, H_ACT, 1'b1);
    lines(1, 3, -1);
    pix(24'hFFFFFF, 1'b1);
    pix(24'h000000, 1'b1);
    chk("sat_r", 32'(out_r), 32'h1F);
    chk("sat_g", 32'(out_g), 32'h3F);
    chk("sat_b", 32'(out_b), 32'h1F);
    line_range(2, H_TOT, H_ACT, 1'b1);
    lines(4, V_ACT, -1); vblank();
    chk("dir_le_cnt", le_cnt, 0);
    chk("dir_fs_cnt", fs_cnt, 1);

    // short line -> one pulse, sticky flag
    dith_mode = 2; le_cnt = 0;
    lines(0, V_ACT, 3); vblank();
    chk("short_line_le_cnt", le_cnt, 1);
    chk("short_line_fe", 32'(frame_err), 32'd1);

    // err_clr in an error-free cycle
    clr_lo = 5; clr_hi = 5;
    line_range(0, H_TOT, 0, 1'b1);
    clr_lo = -1; clr_hi = -1;
    chk("clr_fe", 32'(frame_err), 32'd0);

    // frame with one active line missing -> error on vs falling edge
    le_cnt = 0;
    lines(0, V_ACT - 1, -1); vblank();
    chk("short_frame_le_cnt", le_cnt, 1);
    chk("short_frame_fe", 32'(frame_err), 32'd1);
    clr_lo = 5; clr_hi = 5;
    line_range(0, H_TOT, 0, 1'b1);
    clr_lo = -1; clr_hi = -1;
    chk("clr2_fe", 32'(frame_err), 32'd0);

    // err_clr coincident with a new line-length error
    le_cnt = 0;
    lines(0, 2, -1);
    clr_lo = H_ACT - 1; clr_hi = H_ACT;
    line_range(0, H_TOT, H_ACT - 1, 1'b1);
    clr_lo = -1; clr_hi = -1;
    chk("coinc_fe", 32'(frame_err), 32'd1);
    lines(3, V_ACT, -1); vblank();
    chk("coinc_le_cnt", le_cnt, 1);

    // trailing good frame
    le_cnt = 0; fs_cnt = 0;
    lines(0, V_ACT, -1); vblank();
    chk("final_le_cnt", le_cnt, 0);
    chk("final_fs_cnt", fs_cnt, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
